// File: rtl/conv_pkg.sv
// conv_pkg: shared sizing helpers and the round/shift/saturate used by conv output stages
package conv_pkg;
  function automatic int conv_n(input int k);
    return k * k;
  endfunction
  function automatic int conv_addr_w(input int n);
    return $clog2(n);
  endfunction
  function automatic int conv_lvls(input int n);
    return $clog2(n);
  endfunction
  function automatic int conv_lat(input int n);
    return 2 + $clog2(n);
  endfunction
  function automatic int tree_cnt(input int n, input int l);
    int c;
    c = n;
    for (int i = 0; i < l; i++) c = (c + 1) / 2;
    return c;
  endfunction
  // acc arrives sign-extended to 64 bits so the rounding add cannot overflow
  function automatic logic [63:0] round_shift_sat(input logic signed [63:0] acc, input int s, input int out_w);
    logic signed [63:0] r, mx;
    mx = (64'sd1 <<< out_w) - 64'sd1;
    r = (s == 0) ? acc : (acc + (64'sd1 <<< (s - 1))) >>> s;
    return (r < 0) ? 64'd0 : (r > mx) ? mx : r;
  endfunction
endpackage

// File: rtl/conv_mac_kxk_if.sv
// conv_mac_kxk_if: window beat, kernel programming and result handshake bundle
interface conv_mac_kxk_if
  import conv_pkg::*;
#(
  parameter int K       = 3,
  parameter int PIX_W   = 8,
  parameter int COEF_W  = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
);
  localparam int N  = conv_n(K);
  localparam int AW = conv_addr_w(N);
  logic                      in_valid;
  logic                      in_ready;
  logic [N*PIX_W-1:0]        in_pix;
  logic                      coef_wr_en;
  logic [AW-1:0]             coef_wr_addr;
  logic signed [COEF_W-1:0]  coef_wr_data;
  logic                      shift_wr_en;
  logic [SHIFT_W-1:0]        shift_wr_data;
  logic                      coef_commit;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [ACC_W-1:0]   out_acc;
  logic [OUT_W-1:0]          out_pix;
  modport master (
    output in_valid, in_pix, coef_wr_en, coef_wr_addr, coef_wr_data,
           shift_wr_en, shift_wr_data, coef_commit, out_ready,
    input  in_ready, out_valid, out_acc, out_pix
  );
  modport slave (
    input  in_valid, in_pix, coef_wr_en, coef_wr_addr, coef_wr_data,
           shift_wr_en, shift_wr_data, coef_commit, out_ready,
    output in_ready, out_valid, out_acc, out_pix
  );
endinterface

// File: rtl/conv_add_tree.sv
// conv_add_tree: registered pairwise signed adder tree with valid chain and stall enable
module conv_add_tree
  import conv_pkg::*;
#(
  parameter int N     = 9,
  parameter int IN_W  = 25,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [N*IN_W-1:0]       in_data,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_sum
);
  localparam int L = $clog2(N);
  genvar l;
  for (l = 0; l <= L; l++) begin : g_l
    localparam int C = tree_cnt(N, l);
    logic [C*ACC_W-1:0] d;
    logic               v;
    if (l == 0) begin : g_in
      // sign-extend every product to the accumulator width
      always_comb begin
        d = '0;
        for (int j = 0; j < N; j++) d[j*ACC_W +: ACC_W] = {{(ACC_W-IN_W){in_data[j*IN_W+IN_W-1]}}, in_data[j*IN_W +: IN_W]};
      end
      assign v = in_valid;
    end else begin : g_add
      logic [2*C*ACC_W-1:0] src;
      // zero padding turns an odd leftover operand into a registered pass-through
      assign src = (2*C*ACC_W)'(g_l[l-1].d);
      // pairwise sums of the previous level
      always_ff @(posedge clk)
        if (en)
          for (int j = 0; j < C; j++) d[j*ACC_W +: ACC_W] <= src[2*j*ACC_W +: ACC_W] + src[(2*j+1)*ACC_W +: ACC_W];
      // valid follows its data one level per enabled cycle
      always_ff @(posedge clk)
        if (!rstn) v <= 1'b0;
        else if (en) v <= g_l[l-1].v;
    end
  end
  assign out_valid = g_l[L].v;
  assign out_sum   = g_l[L].d;
endmodule

// File: rtl/conv_mac_kxk.sv
// conv_mac_kxk: KxK window times runtime-loadable kernel, with rounded saturated pixel output
module conv_mac_kxk
  import conv_pkg::*;
#(
  parameter int K       = 3,
  parameter int PIX_W   = 8,
  parameter int COEF_W  = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input logic           clk,
  input logic           rstn,
  conv_mac_kxk_if.slave bus
);
  localparam int N  = conv_n(K);
  localparam int AW = conv_addr_w(N);
  localparam int L  = conv_lvls(N);
  localparam int PW = PIX_W + COEF_W + 1;
  if (K < 2 || ACC_W < PW + $clog2(N) || ACC_W > 63) begin : g_bad
    $error("conv_mac_kxk: illegal parameter set");
  end
  logic                     en;
  logic signed [COEF_W-1:0] sh_coef [N];
  logic signed [COEF_W-1:0] sh_coef_nx [N];
  logic signed [COEF_W-1:0] act_coef [N];
  logic [SHIFT_W-1:0]       sh_shift, sh_shift_nx, act_shift;
  logic [N*PW-1:0]          m_prod;
  logic                     m_valid;
  logic [SHIFT_W-1:0]       tag [L+1];
  logic                     tree_valid;
  logic signed [ACC_W-1:0]  tree_sum;
  assign en           = bus.out_ready || !bus.out_valid;
  assign bus.in_ready = en;
  // shadow bank after this cycle's writes, so a same-cycle commit sees them
  always_comb begin
    for (int i = 0; i < N; i++) sh_coef_nx[i] = (bus.coef_wr_en && bus.coef_wr_addr == AW'(i)) ? bus.coef_wr_data : sh_coef[i];
    sh_shift_nx = bus.shift_wr_en ? bus.shift_wr_data : sh_shift;
  end
  // shadow and active kernel banks; active changes only on commit
  always_ff @(posedge clk)
    if (!rstn) begin
      sh_coef   <= '{default: '0};
      act_coef  <= '{default: '0};
      sh_shift  <= '0;
      act_shift <= '0;
    end else begin
      sh_coef  <= sh_coef_nx;
      sh_shift <= sh_shift_nx;
      if (bus.coef_commit) begin
        act_coef  <= sh_coef_nx;
        act_shift <= sh_shift_nx;
      end
    end
  // multiply stage valid
  always_ff @(posedge clk)
    if (!rstn) m_valid <= 1'b0;
    else if (en) m_valid <= bus.in_valid;
  // multiply stage: unsigned pixel made signed by a zero MSB, times active coefficient
  always_ff @(posedge clk)
    if (en)
      for (int i = 0; i < N; i++) m_prod[i*PW +: PW] <= PW'($signed({1'b0, bus.in_pix[i*PIX_W +: PIX_W]})) * PW'(act_coef[i]);
  // shift value travels with its beat so later commits cannot touch it
  always_ff @(posedge clk)
    if (en) begin
      tag[0] <= act_shift;
      for (int l = 1; l <= L; l++) tag[l] <= tag[l-1];
    end
  conv_add_tree #(.N(N), .IN_W(PW), .ACC_W(ACC_W)) u_tree (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .in_valid  (m_valid),
    .in_data   (m_prod),
    .out_valid (tree_valid),
    .out_sum   (tree_sum)
  );
  // output stage: raw sum plus rounded, shifted, clamped pixel; holds while stalled
  always_ff @(posedge clk)
    if (!rstn) begin
      bus.out_valid <= 1'b0;
      bus.out_acc   <= '0;
      bus.out_pix   <= '0;
    end else if (en) begin
      bus.out_valid <= tree_valid;
      bus.out_acc   <= tree_sum;
      bus.out_pix   <= OUT_W'(round_shift_sat(64'(tree_sum), int'(tag[L]), OUT_W));
    end
endmodule

// File: tb/tb_conv_mac_kxk.sv
// tb_conv_mac_kxk: table vectors plus scoreboarded streams for conv_mac_kxk
module tb_conv_mac_kxk;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  conv_mac_kxk_if bus ();
  conv_mac_kxk dut (.clk(clk), .rstn(rstn), .bus(bus));
  typedef struct { longint acc; int pix; } exp_t;
  typedef struct { int cc; int co; int pc; int po; int sh; longint acc; int pix; } vec_t;
  exp_t   sbq[$];
  vec_t   tv[10];
  int     n_chk = 0, n_fail = 0, got_cnt = 0;
  longint sh_c[9], act_c[9];
  int     sh_s = 0, act_s = 0;
  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [71:0] p);
    exp_t e;
    longint a, d, t, r;
    a = 0;
    for (int i = 0; i < 9; i++) a += longint'(p[i*8 +: 8]) * act_c[i];
    r = a;
    if (act_s != 0) begin
      d = longint'(1) << act_s;
      t = a + d / 2;
      r = t / d;
      if (t % d != 0 && t < 0) r -= 1;
    end
    e.acc = a;
    e.pix = r < 0 ? 0 : r > 255 ? 255 : int'(r);
    return e;
  endfunction
  function automatic logic [71:0] mkpix(input int pc, input int po);
    logic [71:0] p;
    for (int i = 0; i < 9; i++) p[i*8 +: 8] = 8'(i == 4 ? pc : po);
    return p;
  endfunction
  function automatic logic [71:0] rndpix();
    logic [71:0] p;
    for (int i = 0; i < 9; i++) p[i*8 +: 8] = 8'($urandom_range(0, 255));
    return p;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr_coef(input int a, input longint v);
    bus.coef_wr_en = 1'b1;
    bus.coef_wr_addr = 4'(a);
    bus.coef_wr_data = 16'(v);
    tick();
    bus.coef_wr_en = 1'b0;
    if (a < 9) sh_c[a] = v;
  endtask
  task automatic wr_shift(input int v);
    bus.shift_wr_en = 1'b1;
    bus.shift_wr_data = 5'(v);
    tick();
    bus.shift_wr_en = 1'b0;
    sh_s = v;
  endtask
  task automatic commit();
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    act_c = sh_c;
    act_s = sh_s;
  endtask
  task automatic load(input int cc, input int co, input int s);
    for (int i = 0; i < 9; i++) wr_coef(i, i == 4 ? cc : co);
    wr_shift(s);
    commit();
  endtask
  task automatic send(input logic [71:0] p, input bit cm);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_pix = p;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=0 after 100 cycles, required 1");
    end else begin
      sbq.push_back(model(p));
      bus.coef_commit = cm;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.coef_commit = 1'b0;
    if (cm) begin
      act_c = sh_c;
      act_s = sh_s;
    end
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    tick();
    check("drain_empty", longint'(sbq.size()), 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.out_valid && bus.out_ready) begin
      got_cnt++;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: acc=%0d appeared, required no output", bus.out_acc);
      end else begin
        e = sbq.pop_front();
        check("sb_acc", longint'(bus.out_acc), e.acc);
        check("sb_pix", longint'(bus.out_pix), longint'(e.pix));
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end
  initial begin
    int g0, t;
    logic [31:0] held;
    tv[0] = '{1, 0, 200, 7, 0, 200, 200};
    tv[1] = '{1, 1, 255, 255, 3, 2295, 255};
    tv[2] = '{8, -1, 10, 20, 0, -80, 0};
    tv[3] = '{1, 0, 12, 0, 3, 12, 2};
    tv[4] = '{1, 0, 11, 0, 3, 11, 1};
    tv[5] = '{-1, 0, 4, 0, 3, -4, 0};
    tv[6] = '{1, 0, 101, 0, 1, 101, 51};
    tv[7] = '{2, 1, 128, 1, 0, 264, 255};
    tv[8] = '{-1, 0, 5, 9, 1, -5, 0};
    tv[9] = '{-2, 1, 3, 50, 2, 394, 99};
    for (int i = 0; i < 9; i++) begin
      sh_c[i] = 0;
      act_c[i] = 0;
    end
    bus.in_valid = 0;
    bus.in_pix = '0;
    bus.coef_wr_en = 0;
    bus.coef_wr_addr = '0;
    bus.coef_wr_data = '0;
    bus.shift_wr_en = 0;
    bus.shift_wr_data = '0;
    bus.coef_commit = 0;
    bus.out_ready = 1;
    repeat (3) tick();
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_acc", longint'(bus.out_acc), 0);
    check("rst_out_pix", longint'(bus.out_pix), 0);
    check("rst_in_ready", longint'(bus.in_ready), 1);
    rstn = 1;
    tick();
    for (int v = 0; v < 10; v++) begin
      load(tv[v].cc, tv[v].co, tv[v].sh);
      send(mkpix(tv[v].pc, tv[v].po), 1'b0);
      t = 1;
      @(negedge clk);
      while (!bus.out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("latency", longint'(t), 6);
      check("tv_acc", longint'(bus.out_acc), tv[v].acc);
      check("tv_pix", longint'(bus.out_pix), longint'(tv[v].pix));
      drain();
    end
    for (int i = 0; i < 9; i++) wr_coef(i, i - 4);
    wr_shift(2);
    commit();
    g0 = got_cnt;
    fork
      for (int b = 0; b < 20; b++) send(rndpix(), 1'b0);
      begin
        repeat (8) tick();
        bus.out_ready = 0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (c == 0) held = bus.out_acc;
          check("in_ready_stall", longint'(bus.in_ready), 0);
          check("hold_acc", longint'(bus.out_acc), longint'($signed(held)));
        end
        tick();
        bus.out_ready = 1;
        repeat (4) tick();
        bus.out_ready = 0;
        repeat (3) begin
          @(negedge clk);
          check("in_ready_stall2", longint'(bus.in_ready), 0);
        end
        tick();
        bus.out_ready = 1;
      end
    join
    drain();
    check("bp_count", longint'(got_cnt - g0), 20);
    bus.coef_wr_en = 1;
    bus.coef_wr_addr = 4'd4;
    bus.coef_wr_data = 16'sd3;
    bus.shift_wr_en = 1;
    bus.shift_wr_data = 5'd1;
    bus.coef_commit = 1;
    tick();
    bus.coef_wr_en = 0;
    bus.shift_wr_en = 0;
    bus.coef_commit = 0;
    sh_c[4] = 3;
    sh_s = 1;
    act_c = sh_c;
    act_s = sh_s;
    send(rndpix(), 1'b0);
    wr_coef(12, 77);
    commit();
    send(rndpix(), 1'b0);
    drain();
    load(1, 1, 0);
    for (int i = 0; i < 9; i++) wr_coef(i, i == 4 ? 5 : -1);
    wr_shift(1);
    for (int b = 0; b < 10; b++) send(mkpix(10 + b, 10), b == 4);
    drain();
    g0 = got_cnt;
    for (int b = 0; b < 6; b++) send(rndpix(), 1'b0);
    rstn = 0;
    sbq.delete();
    for (int i = 0; i < 9; i++) begin
      sh_c[i] = 0;
      act_c[i] = 0;
    end
    sh_s = 0;
    act_s = 0;
    tick();
    @(negedge clk);
    check("rst_mid_valid", longint'(bus.out_valid), 0);
    check("rst_mid_acc", longint'(bus.out_acc), 0);
    tick();
    rstn = 1;
    repeat (15) tick();
    check("no_stale", longint'(got_cnt - g0), 0);
    check("no_stale_valid", longint'(bus.out_valid), 0);
    send(mkpix(99, 42), 1'b0);
    drain();
    for (int i = 0; i < 9; i++) wr_coef(i, longint'($urandom_range(0, 600)) - 300);
    wr_shift($urandom_range(0, 8));
    commit();
    g0 = got_cnt;
    fork
      for (int b = 0; b < 16; b++) send(rndpix(), 1'b0);
      begin
        for (int c = 0; c < 40; c++) begin
          bus.out_ready = $urandom_range(0, 3) != 0;
          tick();
        end
        bus.out_ready = 1;
      end
    join
    drain();
    check("rnd_count", longint'(got_cnt - g0), 16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
